// File: rtl/fir_decim_multichannel.sv
// Multi-channel decimating signed FIR with shared taps and time-multiplexed MACs.
// Define FIR_SATURATE_EN to clamp results and expose sat_flag_o; otherwise results wrap.
module fir_decim_multichannel #(
  parameter int unsigned TAP_COUNT         = 32,
  parameter int unsigned DECIMATION_FACTOR = 8,
  parameter int unsigned MULT_PER_CYCLE    = 4,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned CHANNELS          = 2,
  parameter int unsigned FRAC_BITS         = 10
) (
  input  logic                                  clock_i,
  input  logic                                  reset_i,
  input  logic [CHANNELS-1:0][DATA_WIDTH-1:0]   in_data_i,
  input  logic                                  in_valid_i,
  output logic                                  in_rd_en_o,
  input  logic [TAP_COUNT-1:0][DATA_WIDTH-1:0]  taps_i,
  output logic [CHANNELS-1:0][DATA_WIDTH-1:0]   out_data_o,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic                                  busy_o
`ifdef FIR_SATURATE_EN
  ,
  output logic [CHANNELS-1:0]                   sat_flag_o
`endif
);

  localparam int unsigned MacCycles = (TAP_COUNT + MULT_PER_CYCLE - 1) / MULT_PER_CYCLE;
  localparam int unsigned SCntW     = (DECIMATION_FACTOR > 1) ? $clog2(DECIMATION_FACTOR) : 1;
  localparam int unsigned MCntW     = (MacCycles > 1) ? $clog2(MacCycles) : 1;
  localparam int unsigned ProdW     = 2 * DATA_WIDTH;
  localparam int unsigned AccW      = ProdW + $clog2(TAP_COUNT);
  localparam logic [SCntW-1:0] SCntLast = SCntW'(DECIMATION_FACTOR - 1);
  localparam logic [MCntW-1:0] MCntLast = MCntW'(MacCycles - 1);

  typedef enum logic [1:0] {StShift, StMac, StOut} state_e;

  state_e                                           state_q;
  logic [SCntW-1:0]                                 sample_cnt_q;
  logic [MCntW-1:0]                                 mac_cnt_q;
  logic [CHANNELS-1:0][TAP_COUNT-1:0][DATA_WIDTH-1:0] line_q;
  logic signed [AccW-1:0]                           acc_q [CHANNELS];
  logic signed [AccW-1:0]                           acc_d [CHANNELS];
  logic [CHANNELS-1:0][DATA_WIDTH-1:0]              out_data_q, result;
  logic                                             out_valid_q, busy_q;
  logic signed [DATA_WIDTH-1:0]                     tap_sel, smp_sel;
  logic signed [ProdW-1:0]                          prod;
`ifdef FIR_SATURATE_EN
  logic signed [AccW-1:0]                           shifted;
  logic [AccW-DATA_WIDTH:0]                         hi_bits;
  logic [CHANNELS-1:0]                              sat_d, sat_q;
`endif

  // Each multiplier slot j picks tap k = mac_cnt*MULT_PER_CYCLE + j; slots past the end add 0.
  always_comb begin
    tap_sel = '0;
    smp_sel = '0;
    prod    = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      acc_d[c] = acc_q[c];
      for (int j = 0; j < int'(MULT_PER_CYCLE); j++) begin
        tap_sel = '0;
        smp_sel = '0;
        for (int k = 0; k < int'(TAP_COUNT); k++) begin
          if ((k % int'(MULT_PER_CYCLE)) == j && (k / int'(MULT_PER_CYCLE)) == int'(mac_cnt_q)) begin
            tap_sel = taps_i[k];
            smp_sel = line_q[c][k];
          end
        end
        prod     = ProdW'(tap_sel) * ProdW'(smp_sel);
        acc_d[c] = acc_d[c] + AccW'(prod);
      end
    end
  end

  always_comb begin
    result = '0;
`ifdef FIR_SATURATE_EN
    sat_d   = '0;
    shifted = '0;
    hi_bits = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      shifted = acc_d[c] >>> FRAC_BITS;
      hi_bits = shifted[AccW-1:DATA_WIDTH-1];
      sat_d[c] = !((&hi_bits) || (~|hi_bits));
      if (sat_d[c]) begin
        result[c] = shifted[AccW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                    : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else begin
        result[c] = shifted[DATA_WIDTH-1:0];
      end
    end
`else
    for (int c = 0; c < int'(CHANNELS); c++) begin
      result[c] = DATA_WIDTH'(acc_d[c] >>> FRAC_BITS);
    end
`endif
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StShift;
      sample_cnt_q <= '0;
      mac_cnt_q    <= '0;
      line_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      for (int c = 0; c < int'(CHANNELS); c++) acc_q[c] <= '0;
`ifdef FIR_SATURATE_EN
      sat_q        <= '0;
`endif
    end else begin
      unique case (state_q)
        StShift: begin
          if (in_valid_i) begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
              line_q[c][0] <= in_data_i[c];
              for (int k = 1; k < int'(TAP_COUNT); k++) line_q[c][k] <= line_q[c][k-1];
            end
            if (sample_cnt_q == SCntLast) begin
              sample_cnt_q <= '0;
              mac_cnt_q    <= '0;
              for (int c = 0; c < int'(CHANNELS); c++) acc_q[c] <= '0;
              busy_q       <= 1'b1;
              state_q      <= StMac;
            end else begin
              sample_cnt_q <= sample_cnt_q + SCntW'(1);
            end
          end
        end
        StMac: begin
          for (int c = 0; c < int'(CHANNELS); c++) acc_q[c] <= acc_d[c];
          if (mac_cnt_q == MCntLast) begin
            out_data_q  <= result;
            out_valid_q <= 1'b1;
`ifdef FIR_SATURATE_EN
            sat_q       <= sat_d;
`endif
            state_q     <= StOut;
          end else begin
            mac_cnt_q <= mac_cnt_q + MCntW'(1);
          end
        end
        StOut: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StShift;
          end
        end
        default: state_q <= StShift;
      endcase
    end
  end

  assign in_rd_en_o  = (state_q == StShift);
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
`ifdef FIR_SATURATE_EN
  assign sat_flag_o  = sat_q;
`endif

endmodule

// File: tb/tb_fir_decim_multichannel.sv
// Directed bench for fir_decim_multichannel: three instances (DEC=1, DEC=4, TAP_COUNT=7)
// sharing clock, reset, input data and taps; one instance is exercised at a time.
module tb_fir_decim_multichannel;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [1:0][15:0]    din = '0;
  logic [7:0][15:0]    taps = '0;
  logic [2:0]          vld = '0;
  logic [2:0]          rd_en, ovld, busy;
  logic                ordy = 1'b0;
  logic [1:0][15:0]    od [3];
`ifdef FIR_SATURATE_EN
  logic [1:0]          sat [3];
`endif
  int                  n_cmp = 0;
  int                  n_bad = 0;
  int                  lat;

  always #5 clk = ~clk;

  fir_decim_multichannel #(.TAP_COUNT(8), .DECIMATION_FACTOR(1), .MULT_PER_CYCLE(4),
                           .DATA_WIDTH(16), .CHANNELS(2), .FRAC_BITS(0)) u_dec1 (
    .clock_i(clk), .reset_i(rst), .in_data_i(din), .in_valid_i(vld[0]), .in_rd_en_o(rd_en[0]),
    .taps_i(taps), .out_data_o(od[0]), .out_valid_o(ovld[0]), .out_ready_i(ordy),
    .busy_o(busy[0])
`ifdef FIR_SATURATE_EN
    , .sat_flag_o(sat[0])
`endif
  );

  fir_decim_multichannel #(.TAP_COUNT(8), .DECIMATION_FACTOR(4), .MULT_PER_CYCLE(4),
                           .DATA_WIDTH(16), .CHANNELS(2), .FRAC_BITS(0)) u_dec4 (
    .clock_i(clk), .reset_i(rst), .in_data_i(din), .in_valid_i(vld[1]), .in_rd_en_o(rd_en[1]),
    .taps_i(taps), .out_data_o(od[1]), .out_valid_o(ovld[1]), .out_ready_i(ordy),
    .busy_o(busy[1])
`ifdef FIR_SATURATE_EN
    , .sat_flag_o(sat[1])
`endif
  );

  fir_decim_multichannel #(.TAP_COUNT(7), .DECIMATION_FACTOR(1), .MULT_PER_CYCLE(4),
                           .DATA_WIDTH(16), .CHANNELS(2), .FRAC_BITS(0)) u_tap7 (
    .clock_i(clk), .reset_i(rst), .in_data_i(din), .in_valid_i(vld[2]), .in_rd_en_o(rd_en[2]),
    .taps_i(taps[6:0]), .out_data_o(od[2]), .out_valid_o(ovld[2]), .out_ready_i(ordy),
    .busy_o(busy[2])
`ifdef FIR_SATURATE_EN
    , .sat_flag_o(sat[2])
`endif
  );

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    rst  = 1'b1;
    vld  = '0;
    ordy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send(input int i, input int d0, input int d1);
    int n = 0;
    din[0] = 16'(d0);
    din[1] = 16'(d1);
    vld[i] = 1'b1;
    while (rd_en[i] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n == 40) check_eq("send_timeout", 0, 1);
    @(negedge clk);
    vld[i] = 1'b0;
  endtask

  task automatic wait_valid(input int i, output int cycles);
    cycles = 0;
    while (ovld[i] !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    if (cycles == 40) check_eq("valid_timeout", 0, 1);
  endtask

  task automatic recv(input int i, input string tag, input int e0, input int e1,
                      input logic [1:0] esat, output int cycles);
    wait_valid(i, cycles);
    check_eq({tag, "_ch0"}, $signed(od[i][0]), e0);
    check_eq({tag, "_ch1"}, $signed(od[i][1]), e1);
`ifdef FIR_SATURATE_EN
    check_eq({tag, "_sat"}, {30'd0, sat[i]}, {30'd0, esat});
`else
    if (esat !== 2'b00) check_eq({tag, "_esat_unused"}, 0, 0);
`endif
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    check_eq({tag, "_vdrop"}, {31'd0, ovld[i]}, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 8; k++) taps[k] = 16'(k + 1);
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("rst%0d_valid", i), {31'd0, ovld[i]}, 0);
      check_eq($sformatf("rst%0d_busy", i), {31'd0, busy[i]}, 0);
      check_eq($sformatf("rst%0d_rden", i), {31'd0, rd_en[i]}, 1);
      check_eq($sformatf("rst%0d_data", i), {16'd0, od[i][0]}, 0);
    end

    // Impulse through taps 1..8.
    for (int n = 0; n < 10; n++) begin
      send(0, (n == 0) ? 1 : 0, 0);
      check_eq($sformatf("imp%0d_busy", n), {31'd0, busy[0]}, 1);
      recv(0, $sformatf("imp%0d", n), (n < 8) ? n + 1 : 0, 0, 2'b00, lat);
      check_eq($sformatf("imp%0d_lat", n), lat, 2);
    end

    // Decimate by 4 on a ramp; ch1 carries the negated ramp.
    for (int k = 0; k < 8; k++) taps[k] = 16'd1;
    apply_reset();
    for (int g = 0; g < 3; g++) begin
      for (int s = 0; s < 4; s++) begin
        send(1, g * 4 + s + 1, -(g * 4 + s + 1));
        if (s < 3) begin
          check_eq($sformatf("dec%0d_%0d_novalid", g, s), {31'd0, ovld[1]}, 0);
          check_eq($sformatf("dec%0d_%0d_rden", g, s), {31'd0, rd_en[1]}, 1);
        end
      end
      if (g == 1) begin
        wait_valid(1, lat);
        check_eq("bp_lat", lat, 2);
        din[0] = 16'd9;
        vld[1] = 1'b1;
        repeat (5) begin
          @(negedge clk);
          check_eq("bp_valid", {31'd0, ovld[1]}, 1);
          check_eq("bp_data", $signed(od[1][0]), 36);
          check_eq("bp_rden", {31'd0, rd_en[1]}, 0);
        end
        vld[1] = 1'b0;
        recv(1, "dec1", 36, -36, 2'b00, lat);
      end else begin
        recv(1, $sformatf("dec%0d", g), (g == 0) ? 10 : 68, (g == 0) ? -10 : -68, 2'b00, lat);
        check_eq($sformatf("dec%0d_lat", g), lat, 2);
      end
    end

    // Seven taps with four multipliers: the unused slot must contribute nothing.
    apply_reset();
    for (int n = 1; n <= 8; n++) begin
      send(2, 3, -3);
      recv(2, $sformatf("t7_%0d", n), 3 * ((n < 7) ? n : 7), -3 * ((n < 7) ? n : 7), 2'b00, lat);
    end

    // Overflow: 32767 * 32767 per tap, and -32768 on ch1.
    for (int k = 0; k < 8; k++) taps[k] = 16'd32767;
    apply_reset();
    for (int n = 1; n <= 8; n++) begin
      send(0, 32767, -32768);
`ifdef FIR_SATURATE_EN
      recv(0, $sformatf("ovf%0d", n), 32767, -32768, 2'b11, lat);
`else
      recv(0, $sformatf("ovf%0d", n), n, (n % 2 == 1) ? -32768 : 0, 2'b00, lat);
`endif
    end

    // Reset in MAC, then in OUT, then a clean impulse.
    for (int k = 0; k < 8; k++) taps[k] = 16'(k + 1);
    apply_reset();
    send(0, 1, 0);
    check_eq("rmac_busy_before", {31'd0, busy[0]}, 1);
    rst = 1'b1;
    #1;
    check_eq("rmac_valid", {31'd0, ovld[0]}, 0);
    check_eq("rmac_busy", {31'd0, busy[0]}, 0);
    check_eq("rmac_rden", {31'd0, rd_en[0]}, 1);
    @(negedge clk);
    rst = 1'b0;
    send(0, 5, 5);
    wait_valid(0, lat);
    check_eq("rout_valid_before", {31'd0, ovld[0]}, 1);
    rst = 1'b1;
    #1;
    check_eq("rout_valid", {31'd0, ovld[0]}, 0);
    check_eq("rout_busy", {31'd0, busy[0]}, 0);
    check_eq("rout_rden", {31'd0, rd_en[0]}, 1);
    check_eq("rout_data", {16'd0, od[0][0]}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 9; n++) begin
      send(0, (n == 0) ? 1 : 0, 0);
      recv(0, $sformatf("imp2_%0d", n), (n < 8) ? n + 1 : 0, 0, 2'b00, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
